// File: rtl/frame_serializer_pkg.sv
// Shared definitions for the frame serializer: FSM state encoding and line levels.
package frame_serializer_pkg;

  // FSM state encoding; PARITY is only reachable when parity is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

  // Serial line levels.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/frame_serializer_if.sv
// Handshake and line bundle between the data source, the serializer and the pin.
// Handshake: a word is accepted on any rising clk_in edge where load and ready are
// both high; ready is high only while the serializer is idle, and load while ready
// is low is dropped (no queueing). data_in only needs to be stable in that cycle.
interface frame_serializer_if #(
  parameter int DATA_W = 8
);
  logic              bit_tick;
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              serial_out;
  logic              start;
  logic              busy;
  logic              done;

  // Source side: drives the word, load and bit timing, observes the line.
  modport master (
    output bit_tick, data_in, load,
    input  ready, serial_out, start, busy, done
  );

  // Serializer side.
  modport slave (
    input  bit_tick, data_in, load,
    output ready, serial_out, start, busy, done
  );
endinterface

// File: rtl/frame_bit_counter.sv
// Loadable, clearable slot counter that advances on tick and saturates at max_val.
module frame_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == max_val);

  // Clear beats load beats tick; holding at terminal count means the index never wraps.
  always_ff @(posedge clk_in) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !tc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Frame serializer: start bit, DATA_W data bits LSB first, optional parity slot,
// STOP_BITS stop slots, one slot per bit_tick. Define FRAME_SERIALIZER_PARITY_EN
// to insert the parity slot (PARITY_ODD picks odd or even sense).
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk_in,
  input  logic               reset,
  frame_serializer_if.slave  bus,
  output logic [2:0]         state_dbg
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int STP_W = 1;

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_ARMED  = 3'(ARMED);
  localparam logic [2:0] S_START  = 3'(START);
  localparam logic [2:0] S_DATA   = 3'(DATA);
  localparam logic [2:0] S_PARITY = 3'(PARITY);
  localparam logic [2:0] S_STOP   = 3'(STOP);

  logic [2:0]        state_q, state_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              line_q, line_n;
  logic              start_q, start_n;
  logic              done_q, done_n;
  logic              idx_clr, idx_en, idx_tc;
  logic              stop_clr, stop_en, stop_tc;
  logic [IDX_W-1:0]  idx_count_unused;
  logic [STP_W-1:0]  stop_count_unused;
  logic              parity_bit;

`ifdef FRAME_SERIALIZER_PARITY_EN
  logic parity_q, parity_n;
  assign parity_bit = parity_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign parity_bit        = 1'b0;
`endif

  assign bus.ready      = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.serial_out = line_q;
  assign bus.start      = start_q;
  assign bus.done       = done_q;
  assign state_dbg      = state_q;

  frame_bit_counter #(.W(IDX_W)) u_idx (
    .clk_in   (clk_in),
    .reset    (reset),
    .clear    (idx_clr),
    .load     (1'b0),
    .load_val ('0),
    .tick     (idx_en),
    .max_val  (IDX_W'(DATA_W - 1)),
    .count    (idx_count_unused),
    .tc       (idx_tc)
  );

  frame_bit_counter #(.W(STP_W)) u_stop (
    .clk_in   (clk_in),
    .reset    (reset),
    .clear    (stop_clr),
    .load     (1'b0),
    .load_val ('0),
    .tick     (stop_en),
    .max_val  (STP_W'(STOP_BITS - 1)),
    .count    (stop_count_unused),
    .tc       (stop_tc)
  );

  // Next state, next shift word and next line value; the line is decoded from the
  // next state so it changes on the same edge that samples bit_tick.
  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    done_n  = 1'b0;
    idx_clr = 1'b0;
    idx_en  = 1'b0;
    stop_en = 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
    parity_n = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          state_n = S_ARMED;
          shift_n = bus.data_in;
`ifdef FRAME_SERIALIZER_PARITY_EN
          parity_n = (^bus.data_in) ^ PARITY_ODD;
`endif
        end
      end
      S_ARMED: if (bus.bit_tick) state_n = S_START;
      S_START: begin
        if (bus.bit_tick) begin
          state_n = S_DATA;
          idx_clr = 1'b1;
        end
      end
      S_DATA: begin
        if (bus.bit_tick) begin
          shift_n = shift_q >> 1;
          idx_en  = 1'b1;
          if (idx_tc) begin
`ifdef FRAME_SERIALIZER_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef FRAME_SERIALIZER_PARITY_EN
      S_PARITY: if (bus.bit_tick) state_n = S_STOP;
`endif
      S_STOP: begin
        if (bus.bit_tick) begin
          stop_en = 1'b1;
          if (stop_tc) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    stop_clr = (state_n == S_STOP) && (state_q != S_STOP);
    start_n  = (state_n == S_START);
    case (state_n)
      S_START:  line_n = LINE_START;
      S_DATA:   line_n = shift_n[0];
      S_PARITY: line_n = parity_bit;
      default:  line_n = LINE_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame without a done pulse.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      line_q  <= LINE_IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      line_q  <= line_n;
      start_q <= start_n;
      done_q  <= done_n;
`ifdef FRAME_SERIALIZER_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

endmodule
